// File: rtl/bram_stream_sext_if.sv
// rtl/bram_stream_sext_if.sv - control, BRAM read port and output stream of bram_stream_sext
interface bram_stream_sext_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              sext_en;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [IN_W-1:0]   mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [ADDR_W:0]   out_idx;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, base, len, sext_en, mem_rdata, out_ready,
        output mem_en, mem_addr, out_valid, out_data, out_idx, out_last, busy, done
    );

    modport slave (
        output start, base, len, sext_en, mem_rdata, out_ready,
        input  mem_en, mem_addr, out_valid, out_data, out_idx, out_last, busy, done
    );
endinterface

// File: rtl/bram_stream_sext.sv
// rtl/bram_stream_sext.sv - BRAM readout engine with sign/zero extension and valid/ready output
module bram_stream_sext #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_stream_sext_if.master   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q, issued, loaded;
    logic              sext_q, rd_pend;
    logic              skid_valid;
    logic [IN_W-1:0]   skid_word;
    logic              out_valid_q, out_last_q;
    logic [OUT_W-1:0]  out_data_q;
    logic [ADDR_W:0]   out_idx_q;

    logic              pop, out_free, do_load, issue;
    logic [2:0]        committed;
    logic [IN_W-1:0]   load_word;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] w, input logic s);
        return {{(OUT_W-IN_W){s & w[IN_W-1]}}, w};
    endfunction

    // Storage is the output register plus one skid entry; a word leaving this
    // cycle frees its slot for a read issued now, which keeps one word per cycle.
    assign pop       = out_valid_q & bus.out_ready;
    assign out_free  = ~out_valid_q | pop;
    assign do_load   = out_free & (skid_valid | rd_pend);
    assign load_word = skid_valid ? skid_word : bus.mem_rdata;
    assign committed = 3'(out_valid_q) + 3'(skid_valid) + 3'(rd_pend) - 3'(pop);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = (bus.len == '0) ? FIN : RUN;
            RUN: begin
                issue = (issued < len_q) && (committed < 3'd2);
                if (pop && out_last_q) state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = base_q + issued[ADDR_W-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state == RUN) || (state == FIN);
    assign bus.done      = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            sext_q      <= 1'b0;
            issued      <= '0;
            loaded      <= '0;
            rd_pend     <= 1'b0;
            skid_valid  <= 1'b0;
            skid_word   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state   <= state_nx;
            rd_pend <= issue;

            if (state == IDLE && bus.start) begin
                base_q <= bus.base;
                len_q  <= bus.len;
                sext_q <= bus.sext_en;
                issued <= '0;
                loaded <= '0;
            end else if (issue) begin
                issued <= issued + 1'b1;
            end

            if (do_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= extend(load_word, sext_q);
                out_idx_q   <= loaded;
                out_last_q  <= (loaded == len_q - 1'b1);
                loaded      <= loaded + 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            // The arriving word parks in the skid entry unless it goes straight out.
            if (out_free) skid_valid <= skid_valid & rd_pend;
            else          skid_valid <= skid_valid | rd_pend;
            if (rd_pend && !(out_free && !skid_valid)) skid_word <= bus.mem_rdata;
        end
    end
endmodule
